// File: rtl/mux4_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : mux4_sched_pkg
// Brief   : Shared widths, select type and one-hot decode for the 4:1 scheduler.
// Revision: 1.0
// ---------------------------------------------------------------------------
package mux4_sched_pkg;

  localparam int N_SRC   = 4;
  localparam int SEL_W   = 2;
  localparam int BURST_W = 4;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [N_SRC-1:0] sel_to_onehot(input sel_t sel);
    logic [N_SRC-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : rr_pick4
// Brief   : Combinational rotating-priority picker; scans start, start+1, ... mod 4.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_pick4
  import mux4_sched_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  sel_t             start,
  output logic             found,
  output sel_t             index
);

  logic [N_SRC-1:0] w_rot;
  sel_t             w_off;

  // Rotate so that bit 0 of w_rot corresponds to the start index.
  always_comb begin
    w_rot = req;
    case (start)
      2'd0:    w_rot = req;
      2'd1:    w_rot = {req[0],   req[3:1]};
      2'd2:    w_rot = {req[1:0], req[3:2]};
      default: w_rot = {req[2:0], req[3]};
    endcase
  end

  always_comb begin
    w_off = 2'd0;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
    else               w_off = 2'd3;
  end

  assign found = |w_rot;
  assign index = start + w_off;

endmodule
`default_nettype wire

// File: rtl/rr_mux4_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : rr_mux4_sched
// Brief   : Round-robin burst scheduler driving the select of a 4:1 datapath mux.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_mux4_sched
  import mux4_sched_pkg::*;
#(
  parameter int MAX_BURST = 4
)(
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [N_SRC-1:0] V,
  input  logic             READY,
  output logic [SEL_W-1:0] S,
  output logic             VALID_O,
  output logic [N_SRC-1:0] ACK
);

  localparam logic [BURST_W-1:0] C_LAST_BEAT = BURST_W'(MAX_BURST - 1);

  sel_t               owner_q, owner_d;
  logic [BURST_W-1:0] burst_q, burst_d;

  logic [N_SRC-1:0] w_owner_oh;
  logic             w_xfer;
  logic             w_burst_end;
  logic [N_SRC-1:0] w_pick_req;
  logic             w_pick_found;
  sel_t             w_pick_idx;

  assign w_owner_oh  = sel_to_onehot(owner_q);
  assign VALID_O     = V[owner_q] & RESETN;
  assign w_xfer      = VALID_O & READY;
  assign ACK         = w_owner_oh & {N_SRC{w_xfer}};
  assign S           = owner_q;
  assign w_burst_end = (burst_q == C_LAST_BEAT);

  // At burst end the current owner is excluded so another requester gets a turn.
  assign w_pick_req  = (w_xfer && w_burst_end) ? (V & ~w_owner_oh) : V;

  rr_pick4 u_pick (
    .req   (w_pick_req),
    .start (owner_q + 2'd1),
    .found (w_pick_found),
    .index (w_pick_idx)
  );

  always_comb begin
    owner_d = owner_q;
    burst_d = burst_q;
    if (!VALID_O) begin
      burst_d = '0;
      if (w_pick_found) owner_d = w_pick_idx;
    end else if (w_xfer) begin
      if (w_burst_end) begin
        burst_d = '0;
        if (w_pick_found) owner_d = w_pick_idx;
      end else begin
        burst_d = burst_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      owner_q <= '0;
      burst_q <= '0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux4_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_rr_mux4_sched
// Brief   : Three scheduler instances (MAX_BURST 1/4/2) against a cycle reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_rr_mux4_sched;

  logic       CLK;
  logic       RESETN;
  logic [3:0] V;
  logic       READY;

  logic [1:0] s_a, s_b, s_c;
  logic       vo_a, vo_b, vo_c;
  logic [3:0] ack_a, ack_b, ack_c;

  int n_total;
  int n_bad;

  int m_owner [3];
  int m_beats [3];
  int m_max   [3];

  rr_mux4_sched #(.MAX_BURST(1)) u_dut_a (
    .CLK(CLK), .RESETN(RESETN), .V(V), .READY(READY),
    .S(s_a), .VALID_O(vo_a), .ACK(ack_a));

  rr_mux4_sched #(.MAX_BURST(4)) u_dut_b (
    .CLK(CLK), .RESETN(RESETN), .V(V), .READY(READY),
    .S(s_b), .VALID_O(vo_b), .ACK(ack_b));

  rr_mux4_sched #(.MAX_BURST(2)) u_dut_c (
    .CLK(CLK), .RESETN(RESETN), .V(V), .READY(READY),
    .S(s_c), .VALID_O(vo_c), .ACK(ack_c));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int i, input string nm, input logic [1:0] s,
                            input logic vo, input logic [3:0] ack);
    logic       ev;
    logic [3:0] eack;
    ev   = RESETN && V[m_owner[i]];
    eack = (ev && READY) ? 4'(1 << m_owner[i]) : 4'd0;
    check_eq({nm, ".S"},       int'(s),   m_owner[i]);
    check_eq({nm, ".VALID_O"}, int'(vo),  int'(ev));
    check_eq({nm, ".ACK"},     int'(ack), int'(eack));
  endtask

  // Reference: first requester scanning owner+1 .. owner+n (mod 4), or -1.
  function automatic int scan_from(input int own, input logic [3:0] v, input int n);
    for (int k = 1; k <= n; k++) begin
      if (v[(own + k) % 4]) return (own + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_adv(input int i, input logic [3:0] v, input logic rd, input logic rn);
    int nxt;
    if (!rn) begin
      m_owner[i] = 0;
      m_beats[i] = 0;
    end else if (!v[m_owner[i]]) begin
      nxt = scan_from(m_owner[i], v, 4);
      if (nxt >= 0) m_owner[i] = nxt;
      m_beats[i] = 0;
    end else if (rd) begin
      m_beats[i]++;
      if (m_beats[i] == m_max[i]) begin
        nxt = scan_from(m_owner[i], v, 3);
        if (nxt >= 0) m_owner[i] = nxt;
        m_beats[i] = 0;
      end
    end
  endtask

  task automatic step(input logic [3:0] v, input logic rd, input logic rn);
    V = v; READY = rd; RESETN = rn;
    #4;
    check_inst(0, "mb1", s_a, vo_a, ack_a);
    check_inst(1, "mb4", s_b, vo_b, ack_b);
    check_inst(2, "mb2", s_c, vo_c, ack_c);
    @(posedge CLK);
    for (int i = 0; i < 3; i++) model_adv(i, v, rd, rn);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    m_max[0] = 1; m_max[1] = 4; m_max[2] = 2;
    for (int i = 0; i < 3; i++) begin
      m_owner[i] = 0;
      m_beats[i] = 0;
    end
    V = 4'b0000; READY = 1'b0; RESETN = 1'b0;
    @(posedge CLK);
    #1;

    // Reset held with all sources requesting, then release.
    repeat (3) step(4'b1111, 1'b1, 1'b0);
    repeat (9) step(4'b1111, 1'b1, 1'b1);

    // Two alternating requesters.
    repeat (12) step(4'b0101, 1'b1, 1'b1);

    // Sole requester.
    repeat (6) step(4'b0010, 1'b1, 1'b1);

    // Backpressure on owner 1, source 3 arriving mid-stall.
    repeat (2) step(4'b0010, 1'b0, 1'b1);
    repeat (3) step(4'b1010, 1'b0, 1'b1);
    repeat (4) step(4'b1010, 1'b1, 1'b1);

    // Idle then a single late request.
    repeat (2) step(4'b0000, 1'b1, 1'b1);
    repeat (3) step(4'b1000, 1'b1, 1'b1);

    // Reset pulse in the middle of a burst.
    repeat (2) step(4'b0100, 1'b1, 1'b1);
    step(4'b0100, 1'b1, 1'b0);
    repeat (6) step(4'b0101, 1'b1, 1'b1);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      step(4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 40) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
